// File: rtl/rvfi_formal_pkg.sv
// Shared definitions for the RVFI formal front-end: order width, modular
// order distance and the packed-payload field layout used by all consumers.
package rvfi_formal_pkg;

    localparam int ORDER_W = 8;

    typedef logic [ORDER_W-1:0] order_t;

    // Distance from b forward to a, modulo 2^ORDER_W; wrap needs no special case.
    function automatic order_t order_dist(input order_t a, input order_t b);
        return a - b;
    endfunction

    // Bit offsets of each field inside the packed payload built by the wrapper.
    typedef enum int {
        PL_INSN_LSB     = 0,
        PL_RS1_ADDR_LSB = 32,
        PL_RS2_ADDR_LSB = 37,
        PL_RD_ADDR_LSB  = 42,
        PL_PC_LSB       = 47,
        PL_MEM_LSB      = 79
    } payload_off_e;

    localparam int PL_INSN_W = 32;
    localparam int PL_REG_W  = 5;
    localparam int PL_PC_W   = 32;

endpackage

// File: rtl/rvfi_order_slot.sv
// One reorder slot: a valid bit with async reset plus order/payload data
// registers loaded on write-enable.
module rvfi_order_slot
    import rvfi_formal_pkg::*;
#(
    parameter int PW = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               clr,
    input  logic [ORDER_W-1:0] wr_order,
    input  logic [PW-1:0]      wr_payload,
    output logic               valid,
    output logic [ORDER_W-1:0] order,
    output logic [PW-1:0]      payload
);

    logic               valid_q,   valid_d;
    logic [ORDER_W-1:0] order_q,   order_d;
    logic [PW-1:0]      payload_q, payload_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        valid_d   = valid_q;
        order_d   = order_q;
        payload_d = payload_q;
        if (clr) begin
            valid_d = 1'b0;
        end
        if (wr_en) begin
            valid_d   = 1'b1;
            order_d   = wr_order;
            payload_d = wr_payload;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: data registers carry no reset; they are only observed while valid_q is set.
    always_ff @(posedge clk) begin
        order_q   <= order_d;
        payload_q <= payload_d;
    end

    assign valid   = valid_q;
    assign order   = order_q;
    assign payload = payload_q;

endmodule

// File: rtl/rvfi_order_serializer.sv
// Reorders multi-channel RVFI retirements by rvfi_order and emits them one per
// cycle, strictly ascending, flagging any capacity or collision violation.
module rvfi_order_serializer
    import rvfi_formal_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int PW    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRET-1:0]         in_valid,
    input  logic [NRET*ORDER_W-1:0] in_order,
    input  logic [NRET*PW-1:0]      in_payload,
    output logic                    out_valid,
    output logic [ORDER_W-1:0]      out_order,
    output logic [PW-1:0]           out_payload,
    output logic [ORDER_W-1:0]      next_order,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [ORDER_W:0] DEPTH_LIM = (ORDER_W+1)'(DEPTH);

    logic [DEPTH-1:0]   slot_valid;
    logic [ORDER_W-1:0] slot_order   [DEPTH];
    logic [PW-1:0]      slot_payload [DEPTH];
    logic [DEPTH-1:0]   wr_en;
    logic [DEPTH-1:0]   clr;
    logic [ORDER_W-1:0] wr_order     [DEPTH];
    logic [PW-1:0]      wr_payload   [DEPTH];
    logic [DEPTH-1:0]   claimed;
    logic               insert_err;

    logic               out_valid_q,   out_valid_d;
    logic [ORDER_W-1:0] out_order_q,   out_order_d;
    logic [PW-1:0]      out_payload_q, out_payload_d;
    logic [ORDER_W-1:0] next_order_q,  next_order_d;
    logic               overflow_q,    overflow_d;
    logic [IW-1:0]      next_idx;
    logic               drain;
    logic [IW:0]        occ_cnt;

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        rvfi_order_slot #(.PW(PW)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (wr_en[s]),
            .clr       (clr[s]),
            .wr_order  (wr_order[s]),
            .wr_payload(wr_payload[s]),
            .valid     (slot_valid[s]),
            .order     (slot_order[s]),
            .payload   (slot_payload[s])
        );
    end

    // Lower channels claim a slot first; legality uses pre-edge slot state only.
    always_comb begin
        logic [ORDER_W-1:0] ord_c;
        logic [IW-1:0]      idx_c;
        wr_en      = '0;
        claimed    = '0;
        insert_err = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            wr_order[s]   = '0;
            wr_payload[s] = '0;
        end
        for (int c = 0; c < NRET; c++) begin
            ord_c = in_order[c*ORDER_W +: ORDER_W];
            idx_c = ord_c[IW-1:0];
            if (in_valid[c]) begin
                if (({1'b0, order_dist(ord_c, next_order_q)} < DEPTH_LIM) &&
                    !slot_valid[idx_c] && !claimed[idx_c]) begin
                    wr_en[idx_c]      = 1'b1;
                    wr_order[idx_c]   = ord_c;
                    wr_payload[idx_c] = in_payload[c*PW +: PW];
                end else begin
                    insert_err = 1'b1;
                end
                claimed[idx_c] = 1'b1;
            end
        end
    end

    always_comb begin
        next_idx      = next_order_q[IW-1:0];
        drain         = slot_valid[next_idx];
        clr           = '0;
        clr[next_idx] = drain;
        out_valid_d   = drain;
        out_order_d   = drain ? slot_order[next_idx]   : out_order_q;
        out_payload_d = drain ? slot_payload[next_idx] : out_payload_q;
        next_order_d  = next_order_q + ORDER_W'(drain);
        overflow_d    = overflow_q | insert_err;
    end

    always_comb begin
        occ_cnt = '0;
        for (int s = 0; s < DEPTH; s++) begin
            occ_cnt = occ_cnt + (IW+1)'(slot_valid[s]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_order_q   <= '0;
            out_payload_q <= '0;
            next_order_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_order_q   <= out_order_d;
            out_payload_q <= out_payload_d;
            next_order_q  <= next_order_d;
            overflow_q    <= overflow_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_order   = out_order_q;
    assign out_payload = out_payload_q;
    assign next_order  = next_order_q;
    assign overflow    = overflow_q;
    assign occupancy   = occ_cnt;

endmodule
